// File: rtl/vc_funnel_pkg.sv
// Shared definitions for the round-robin val/rdy funnel.
// Holds the helper that sizes the grant / source-ID field from the
// number of requesters so every file derives the same width.
package vc_funnel_pkg;

  // Width of an encoded index into n requesters. Never below 1 bit.
  function automatic int sel_nbits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vc_rr_funnel_if.sv
// Bundle of the funnel's handshake and message signals.
//   in_val  [p_ninputs]          per-input valid
//   in_rdy  [p_ninputs]          per-input ready (one-hot or zero)
//   in_msg  [p_ninputs*p_nbits]  flattened messages, input i at [i*p_nbits +: p_nbits]
//   out_val                      output register holds a message
//   out_rdy                      downstream ready
//   out_msg [p_nbits]            registered message
//   out_src [c_sel_nbits]        index of the input that supplied out_msg
// master: the environment (requesters + downstream consumer).
// slave : the funnel itself.
interface vc_rr_funnel_if #(
  parameter int p_nbits   = 32,
  parameter int p_ninputs = 4
);
  import vc_funnel_pkg::*;

  localparam int c_sel_nbits = sel_nbits(p_ninputs);

  logic [p_ninputs-1:0]         in_val;
  logic [p_ninputs-1:0]         in_rdy;
  logic [p_ninputs*p_nbits-1:0] in_msg;
  logic                         out_val;
  logic                         out_rdy;
  logic [p_nbits-1:0]           out_msg;
  logic [c_sel_nbits-1:0]       out_src;

  modport master (
    output in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg, out_src
  );

  modport slave (
    input  in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg, out_src
  );

endinterface

// File: rtl/vc_rr_arb_enc.sv
// Round-robin arbiter with encoded grant.
// Owns the priority pointer: the search for a valid request starts at ptr
// and wraps. The pointer moves to grant+1 only when en says the grant was
// accepted, so a stalled requester keeps its priority.
//   clk      clock
//   reset    asynchronous active-low reset (ptr -> 0)
//   req      per-requester request
//   en       grant accepted this cycle
//   grant    encoded index of the winning requester
//   any_val  at least one request present
module vc_rr_arb_enc #(
  parameter int p_ninputs   = 4,
  parameter int c_sel_nbits = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_ninputs-1:0]   req,
  input  logic                   en,
  output logic [c_sel_nbits-1:0] grant,
  output logic                   any_val
);

  logic [c_sel_nbits-1:0] ptr_q;
  logic [c_sel_nbits-1:0] ptr_d;
  logic [c_sel_nbits-1:0] grant_hi;
  logic [c_sel_nbits-1:0] grant_lo;
  logic                   found_hi;

  assign any_val = |req;

  // Two candidates: lowest requester at or above ptr, and lowest overall.
  // The first one wins; otherwise the search has wrapped to the second.
  // Scanning downward lets the lowest index overwrite earlier hits.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    found_hi = 1'b0;
    for (int i = p_ninputs - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_lo = c_sel_nbits'(i);
        if (i >= int'(ptr_q)) begin
          grant_hi = c_sel_nbits'(i);
          found_hi = 1'b1;
        end
      end
    end
    grant = found_hi ? grant_hi : grant_lo;
  end

  // Explicit wrap keeps ptr inside 0..p_ninputs-1 for non-power-of-two N.
  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      if (grant == c_sel_nbits'(p_ninputs - 1)) ptr_d = '0;
      else                                      ptr_d = grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vc_rr_funnel.sv
// N-to-1 val/rdy funnel: a round-robin arbiter picks one valid input per
// cycle and its encoded grant selects the message loaded into a single
// registered output stage.
//   clk    clock, rising edge
//   reset  asynchronous active-low reset
//   bus    vc_rr_funnel_if.slave: in_val/in_rdy/in_msg, out_val/out_rdy/out_msg/out_src
// The output register can reload in the same cycle it drains, giving one
// message per cycle. in_rdy is combinational on in_val and out_rdy.
module vc_rr_funnel
  import vc_funnel_pkg::*;
#(
  parameter int p_nbits   = 32,
  parameter int p_ninputs = 4
) (
  input  logic           clk,
  input  logic           reset,
  vc_rr_funnel_if.slave  bus
);

  localparam int c_sel_nbits = sel_nbits(p_ninputs);

  logic                   go;
  logic                   en;
  logic                   any_val;
  logic [c_sel_nbits-1:0] grant;
  logic [p_nbits-1:0]     sel_msg;

  logic                   out_val_q;
  logic                   out_val_d;
  logic [p_nbits-1:0]     out_msg_q;
  logic [p_nbits-1:0]     out_msg_d;
  logic [c_sel_nbits-1:0] out_src_q;
  logic [c_sel_nbits-1:0] out_src_d;

  // Register is free if empty or being drained this cycle. Holding reset
  // low blocks acceptance so no input sees rdy while reset is asserted.
  assign go = !out_val_q || bus.out_rdy;
  assign en = reset && go && any_val;

  vc_rr_arb_enc #(
    .p_ninputs   (p_ninputs),
    .c_sel_nbits (c_sel_nbits)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.in_val),
    .en      (en),
    .grant   (grant),
    .any_val (any_val)
  );

  always_comb begin
    bus.in_rdy = '0;
    for (int i = 0; i < p_ninputs; i++) begin
      bus.in_rdy[i] = en && (grant == c_sel_nbits'(i));
    end
  end

  // Only the granted slice reaches sel_msg, so other inputs' data
  // (including X) never propagates.
  always_comb begin
    sel_msg = '0;
    for (int i = 0; i < p_ninputs; i++) begin
      if (grant == c_sel_nbits'(i)) sel_msg = bus.in_msg[i*p_nbits +: p_nbits];
    end
  end

  always_comb begin
    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    out_src_d = out_src_q;
    if (en) begin
      out_val_d = 1'b1;
      out_msg_d = sel_msg;
      out_src_d = grant;
    end else if (out_val_q && bus.out_rdy) begin
      out_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      out_src_q <= '0;
    end else begin
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
      out_src_q <= out_src_d;
    end
  end

  assign bus.out_val = out_val_q;
  assign bus.out_msg = out_msg_q;
  assign bus.out_src = out_src_q;

endmodule

// File: tb/tb_vc_rr_funnel.sv
// Directed bench for vc_rr_funnel with 4 inputs of 32 bits.
module tb_vc_rr_funnel;

  localparam int NB = 32;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic reset;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  vc_rr_funnel_if #(.p_nbits(NB), .p_ninputs(NI)) bus ();

  vc_rr_funnel #(.p_nbits(NB), .p_ninputs(NI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_msgs(input logic [31:0] base);
    for (int i = 0; i < NI; i++) bus.in_msg[i*NB +: NB] = base + 32'(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    bus.in_val  = '0;
    bus.out_rdy = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    bus.in_val  = 4'hF;
    bus.out_rdy = 1'b1;
    set_msgs(32'h5555_0000);
    #2;
    vecs++; if (bus.in_rdy !== 4'b0000) begin errs++; $display("FAIL rst_held_in_rdy got %b want 0000", bus.in_rdy); end
    vecs++; if (bus.out_val !== 1'b0) begin errs++; $display("FAIL rst_held_out_val got %b want 0", bus.out_val); end
    vecs++; if (bus.out_msg !== 32'h0) begin errs++; $display("FAIL rst_held_out_msg got %h want 0", bus.out_msg); end
    vecs++; if (bus.out_src !== 2'd0) begin errs++; $display("FAIL rst_held_out_src got %0d want 0", bus.out_src); end
    @(negedge clk);
    bus.in_val = '0;
    reset      = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      vecs++; if (bus.out_val !== 1'b0) begin errs++; $display("FAIL idle_out_val cyc %0d got %b want 0", k, bus.out_val); end
      vecs++; if (bus.in_rdy !== 4'b0000) begin errs++; $display("FAIL idle_in_rdy cyc %0d got %b want 0000", k, bus.in_rdy); end
      vecs++; if (bus.out_msg !== 32'h0) begin errs++; $display("FAIL idle_out_msg cyc %0d got %h want 0", k, bus.out_msg); end
    end
  endtask

  task automatic test_single();
    set_msgs(32'hDEAD_0000);
    bus.in_msg[1*NB +: NB] = 32'hA5A5_0001;
    bus.in_val  = 4'b0010;
    bus.out_rdy = 1'b1;
    #1;
    vecs++; if (bus.in_rdy !== 4'b0010) begin errs++; $display("FAIL single_in_rdy got %b want 0010", bus.in_rdy); end
    step();
    bus.in_val = '0;
    vecs++; if (bus.out_val !== 1'b1) begin errs++; $display("FAIL single_out_val got %b want 1", bus.out_val); end
    vecs++; if (bus.out_msg !== 32'hA5A5_0001) begin errs++; $display("FAIL single_out_msg got %h want a5a50001", bus.out_msg); end
    vecs++; if (bus.out_src !== 2'd1) begin errs++; $display("FAIL single_out_src got %0d want 1", bus.out_src); end
    #1;
    vecs++; if (bus.in_rdy !== 4'b0000) begin errs++; $display("FAIL single_noval_rdy got %b want 0000", bus.in_rdy); end
    step();
    vecs++; if (bus.out_val !== 1'b0) begin errs++; $display("FAIL drain_out_val got %b want 0", bus.out_val); end
    vecs++; if (bus.out_msg !== 32'hA5A5_0001) begin errs++; $display("FAIL drain_msg_hold got %h want a5a50001", bus.out_msg); end
    // Pointer should now be 2: with all valid, input 2 wins.
    set_msgs(32'h0000_0100);
    bus.in_val = 4'hF;
    #1;
    vecs++; if (bus.in_rdy !== 4'b0100) begin errs++; $display("FAIL ptr_after_single rdy got %b want 0100", bus.in_rdy); end
    step();
    bus.in_val = '0;
    vecs++; if (bus.out_src !== 2'd2) begin errs++; $display("FAIL ptr_after_single src got %0d want 2", bus.out_src); end
    vecs++; if (bus.out_msg !== 32'h102) begin errs++; $display("FAIL ptr_after_single msg got %h want 102", bus.out_msg); end
    step();
  endtask

  task automatic test_rotate();
    do_reset();
    set_msgs(32'h0000_0100);
    bus.in_val  = 4'hF;
    bus.out_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [1:0]  es;
      logic [3:0]  er;
      logic [31:0] em;
      es = 2'(k % 4);
      er = 4'b0001 << es;
      em = 32'h100 + 32'(es);
      #1;
      vecs++; if (bus.in_rdy !== er) begin errs++; $display("FAIL rot_in_rdy k%0d got %b want %b", k, bus.in_rdy, er); end
      step();
      vecs++; if (bus.out_val !== 1'b1) begin errs++; $display("FAIL rot_out_val k%0d got %b want 1", k, bus.out_val); end
      vecs++; if (bus.out_src !== es) begin errs++; $display("FAIL rot_out_src k%0d got %0d want %0d", k, bus.out_src, es); end
      vecs++; if (bus.out_msg !== em) begin errs++; $display("FAIL rot_out_msg k%0d got %h want %h", k, bus.out_msg, em); end
    end
    bus.in_val = '0;
    step();
  endtask

  // ptr enters at 2 (last grant in rotation was 1).
  task automatic test_stall();
    set_msgs(32'h0000_0100);
    bus.in_val  = 4'b0001;
    bus.out_rdy = 1'b1;
    step();
    vecs++; if (bus.out_msg !== 32'h100) begin errs++; $display("FAIL stall_setup_msg got %h want 100", bus.out_msg); end
    bus.in_val  = 4'b1100;
    bus.out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vecs++; if (bus.in_rdy !== 4'b0000) begin errs++; $display("FAIL stall_in_rdy k%0d got %b want 0000", k, bus.in_rdy); end
      step();
      vecs++; if (bus.out_val !== 1'b1) begin errs++; $display("FAIL stall_out_val k%0d got %b want 1", k, bus.out_val); end
      vecs++; if (bus.out_msg !== 32'h100) begin errs++; $display("FAIL stall_out_msg k%0d got %h want 100", k, bus.out_msg); end
      vecs++; if (bus.out_src !== 2'd0) begin errs++; $display("FAIL stall_out_src k%0d got %0d want 0", k, bus.out_src); end
    end
    bus.out_rdy = 1'b1;
    #1;
    vecs++; if (bus.in_rdy !== 4'b0100) begin errs++; $display("FAIL unstall_in_rdy got %b want 0100", bus.in_rdy); end
    step();
    vecs++; if (bus.out_src !== 2'd2) begin errs++; $display("FAIL unstall_out_src got %0d want 2", bus.out_src); end
    vecs++; if (bus.out_msg !== 32'h102) begin errs++; $display("FAIL unstall_out_msg got %h want 102", bus.out_msg); end
    bus.in_val = '0;
    step();
    vecs++; if (bus.out_val !== 1'b0) begin errs++; $display("FAIL unstall_drain got %b want 0", bus.out_val); end
  endtask

  // ptr enters at 3.
  task automatic test_wrap();
    logic [1:0] seq [3];
    seq[0] = 2'd0; seq[1] = 2'd2; seq[2] = 2'd0;
    set_msgs(32'h0000_0200);
    bus.in_val  = 4'b0101;
    bus.out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vecs++; if (bus.out_src !== seq[k]) begin errs++; $display("FAIL wrap_out_src k%0d got %0d want %0d", k, bus.out_src, seq[k]); end
      vecs++; if (bus.out_msg !== 32'h200 + 32'(seq[k])) begin errs++; $display("FAIL wrap_out_msg k%0d got %h want %h", k, bus.out_msg, 32'h200 + 32'(seq[k])); end
    end
    bus.in_val = '0;
    step();
  endtask

  // ptr enters at 1.
  task automatic test_async_reset();
    set_msgs(32'h0000_0300);
    bus.in_val  = 4'b0010;
    bus.out_rdy = 1'b0;
    step();
    bus.in_val = '0;
    vecs++; if (bus.out_val !== 1'b1) begin errs++; $display("FAIL areset_setup_val got %b want 1", bus.out_val); end
    #2;
    reset = 1'b0;
    #1;
    vecs++; if (bus.out_val !== 1'b0) begin errs++; $display("FAIL areset_out_val got %b want 0", bus.out_val); end
    vecs++; if (bus.out_msg !== 32'h0) begin errs++; $display("FAIL areset_out_msg got %h want 0", bus.out_msg); end
    vecs++; if (bus.out_src !== 2'd0) begin errs++; $display("FAIL areset_out_src got %0d want 0", bus.out_src); end
    bus.in_val = 4'b1010;
    #1;
    vecs++; if (bus.in_rdy !== 4'b0000) begin errs++; $display("FAIL areset_in_rdy got %b want 0000", bus.in_rdy); end
    #2;
    reset = 1'b1;
    #1;
    vecs++; if (bus.in_rdy !== 4'b0010) begin errs++; $display("FAIL post_reset_in_rdy got %b want 0010", bus.in_rdy); end
    step();
    bus.in_val = '0;
    vecs++; if (bus.out_src !== 2'd1) begin errs++; $display("FAIL post_reset_src got %0d want 1", bus.out_src); end
    vecs++; if (bus.out_msg !== 32'h301) begin errs++; $display("FAIL post_reset_msg got %h want 301", bus.out_msg); end
  endtask

  initial begin
    bus.in_val  = '0;
    bus.in_msg  = '0;
    bus.out_rdy = 1'b0;
    test_reset();
    test_single();
    test_rotate();
    test_stall();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
